// File: rtl/reg_file_sb_if.sv
// rtl/reg_file_sb_if.sv - read, write, issue and scoreboard signals of the register file
interface reg_file_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] RSaddr_i;
  logic [ADDR_W-1:0] RTaddr_i;
  logic [DATA_W-1:0] RSdata_o;
  logic [DATA_W-1:0] RTdata_o;
  logic              RSbusy_o;
  logic              RTbusy_o;
  logic              WAen_i;
  logic [ADDR_W-1:0] WAaddr_i;
  logic [DATA_W-1:0] WAdata_i;
  logic              WBen_i;
  logic [ADDR_W-1:0] WBaddr_i;
  logic [DATA_W-1:0] WBdata_i;
  logic              Issue_i;
  logic [ADDR_W-1:0] Issueaddr_i;
  logic              Flush_i;
  logic [ADDR_W:0]   BusyCnt_o;

  modport master (
    output RSaddr_i, RTaddr_i, WAen_i, WAaddr_i, WAdata_i,
    output WBen_i, WBaddr_i, WBdata_i, Issue_i, Issueaddr_i, Flush_i,
    input  RSdata_o, RTdata_o, RSbusy_o, RTbusy_o, BusyCnt_o
  );

  modport slave (
    input  RSaddr_i, RTaddr_i, WAen_i, WAaddr_i, WAdata_i,
    input  WBen_i, WBaddr_i, WBdata_i, Issue_i, Issueaddr_i, Flush_i,
    output RSdata_o, RTdata_o, RSbusy_o, RTbusy_o, BusyCnt_o
  );
endinterface

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - two-write-port register file with bypass and busy scoreboard
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  reg_file_sb_if.slave rf
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;

  logic wa_ok, wb_ok;
  logic zs, zt;
  logic s_hit_a, s_hit_b, t_hit_a, t_hit_b;

  assign wa_ok = rf.WAen_i && !(ZR && rf.WAaddr_i == '0);
  assign wb_ok = rf.WBen_i && !(ZR && rf.WBaddr_i == '0);

  assign zs = ZR && rf.RSaddr_i == '0;
  assign zt = ZR && rf.RTaddr_i == '0;

  assign s_hit_a = rf.WAen_i && rf.WAaddr_i == rf.RSaddr_i;
  assign s_hit_b = rf.WBen_i && rf.WBaddr_i == rf.RSaddr_i;
  assign t_hit_a = rf.WAen_i && rf.WAaddr_i == rf.RTaddr_i;
  assign t_hit_b = rf.WBen_i && rf.WBaddr_i == rf.RTaddr_i;

  // Port B bypass wins over port A, matching the store priority on a collision.
  assign rf.RSdata_o = zs      ? '0          :
                       s_hit_b ? rf.WBdata_i :
                       s_hit_a ? rf.WAdata_i : regs_q[rf.RSaddr_i];
  assign rf.RTdata_o = zt      ? '0          :
                       t_hit_b ? rf.WBdata_i :
                       t_hit_a ? rf.WAdata_i : regs_q[rf.RTaddr_i];

  assign rf.RSbusy_o = !zs && busy_q[rf.RSaddr_i] && !(s_hit_a || s_hit_b);
  assign rf.RTbusy_o = !zt && busy_q[rf.RTaddr_i] && !(t_hit_a || t_hit_b);
  assign rf.BusyCnt_o = cnt_q;

  // A same-cycle issue is a new producer, so it beats both flush and writeback clears.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = '0;
    for (int r = 0; r < DEPTH; r++) begin
      if (rf.Flush_i) busy_d[r] = 1'b0;
      if ((rf.WAen_i && rf.WAaddr_i == ADDR_W'(r)) ||
          (rf.WBen_i && rf.WBaddr_i == ADDR_W'(r))) busy_d[r] = 1'b0;
      if (rf.Issue_i && rf.Issueaddr_i == ADDR_W'(r)) busy_d[r] = 1'b1;
      if (ZR && r == 0) busy_d[r] = 1'b0;
      cnt_d = cnt_d + (ADDR_W+1)'(busy_d[r]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < DEPTH; r++) regs_q[r] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wa_ok) regs_q[rf.WAaddr_i] <= rf.WAdata_i;
      if (wb_ok) regs_q[rf.WBaddr_i] <= rf.WBdata_i;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - directed vector bench for reg_file_sb
module tb_reg_file_sb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_file_sb_if #(.DATA_W(32), .ADDR_W(5)) bus0 ();
  reg_file_sb_if #(.DATA_W(32), .ADDR_W(5)) bus1 ();

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut0 (.clk_i(clk), .rst_i(rst), .rf(bus0));
  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) dut1 (.clk_i(clk), .rst_i(rst), .rf(bus1));

  typedef struct {
    logic        wa_en; logic [4:0] wa_addr; logic [31:0] wa_data;
    logic        wb_en; logic [4:0] wb_addr; logic [31:0] wb_data;
    logic        iss;   logic [4:0] iss_addr; logic flush;
    logic [4:0]  rs;    logic [4:0] rt;
    logic [31:0] e_rs;  logic [31:0] e_rt;
    logic        e_rsb; logic e_rtb; logic [5:0] e_cnt;
  } vec_t;

  vec_t vecs [17];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus0.RSaddr_i = '0; bus0.RTaddr_i = '0;
    bus0.WAen_i = 0; bus0.WAaddr_i = '0; bus0.WAdata_i = '0;
    bus0.WBen_i = 0; bus0.WBaddr_i = '0; bus0.WBdata_i = '0;
    bus0.Issue_i = 0; bus0.Issueaddr_i = '0; bus0.Flush_i = 0;
    bus1.RSaddr_i = '0; bus1.RTaddr_i = '0;
    bus1.WAen_i = 0; bus1.WAaddr_i = '0; bus1.WAdata_i = '0;
    bus1.WBen_i = 0; bus1.WBaddr_i = '0; bus1.WBdata_i = '0;
    bus1.Issue_i = 0; bus1.Issueaddr_i = '0; bus1.Flush_i = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          wa  addr data          wb  addr data          iss addr fl  rs  rt  e_rs          e_rt          rsb rtb cnt
    vecs[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 32'h0,      0, 0,  0, 5,  0,  32'hDEADBEEF, 32'h0,        0, 0, 0};
    vecs[1]  = '{0, 0, 32'h0,        0, 0, 32'h0,      0, 0,  0, 5,  5,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0};
    vecs[2]  = '{1, 7, 32'h11,       1, 7, 32'h22,     0, 0,  0, 7,  5,  32'h22,       32'hDEADBEEF, 0, 0, 0};
    vecs[3]  = '{0, 0, 32'h0,        0, 0, 32'h0,      0, 0,  0, 7,  0,  32'h22,       32'h0,        0, 0, 0};
    vecs[4]  = '{0, 0, 32'h0,        0, 0, 32'h0,      1, 3,  0, 3,  0,  32'h0,        32'h0,        0, 0, 0};
    vecs[5]  = '{0, 0, 32'h0,        1, 3, 32'h99,     0, 0,  0, 3,  3,  32'h99,       32'h99,       0, 0, 1};
    vecs[6]  = '{0, 0, 32'h0,        0, 0, 32'h0,      1, 4,  0, 3,  5,  32'h99,       32'hDEADBEEF, 0, 0, 0};
    vecs[7]  = '{1, 4, 32'h44,       0, 0, 32'h0,      1, 4,  0, 4,  3,  32'h44,       32'h99,       0, 0, 1};
    vecs[8]  = '{0, 0, 32'h0,        1, 4, 32'h45,     1, 1,  0, 4,  4,  32'h45,       32'h45,       0, 0, 1};
    vecs[9]  = '{0, 0, 32'h0,        0, 0, 32'h0,      1, 2,  0, 1,  4,  32'h0,        32'h45,       1, 0, 1};
    vecs[10] = '{0, 0, 32'h0,        0, 0, 32'h0,      1, 9,  0, 2,  9,  32'h0,        32'h0,        1, 0, 2};
    vecs[11] = '{0, 0, 32'h0,        0, 0, 32'h0,      1, 2,  1, 9,  1,  32'h0,        32'h0,        1, 1, 3};
    vecs[12] = '{0, 0, 32'h0,        0, 0, 32'h0,      0, 0,  0, 2,  9,  32'h0,        32'h0,        1, 0, 1};
    vecs[13] = '{1, 0, 32'h1234,     0, 0, 32'h0,      1, 0,  0, 0,  2,  32'h0,        32'h0,        0, 1, 1};
    vecs[14] = '{0, 0, 32'h0,        0, 0, 32'h0,      0, 0,  1, 0,  0,  32'h0,        32'h0,        0, 0, 1};
    vecs[15] = '{0, 0, 32'h0,        1, 31, 32'hABCD,  1, 31, 0, 31, 2,  32'hABCD,     32'h0,        0, 0, 0};
    vecs[16] = '{0, 0, 32'h0,        0, 0, 32'h0,      0, 0,  0, 31, 7,  32'hABCD,     32'h22,       1, 0, 1};

    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    bus0.RSaddr_i = 5; bus0.RTaddr_i = 31;
    @(negedge clk);
    chk("reset_rs_data", bus0.RSdata_o, 32'h0);
    chk("reset_rs_busy", {31'b0, bus0.RSbusy_o}, 32'h0);
    chk("reset_cnt", {26'b0, bus0.BusyCnt_o}, 32'h0);
    tick();

    for (int i = 0; i < 17; i++) begin
      bus0.WAen_i = vecs[i].wa_en; bus0.WAaddr_i = vecs[i].wa_addr; bus0.WAdata_i = vecs[i].wa_data;
      bus0.WBen_i = vecs[i].wb_en; bus0.WBaddr_i = vecs[i].wb_addr; bus0.WBdata_i = vecs[i].wb_data;
      bus0.Issue_i = vecs[i].iss; bus0.Issueaddr_i = vecs[i].iss_addr; bus0.Flush_i = vecs[i].flush;
      bus0.RSaddr_i = vecs[i].rs; bus0.RTaddr_i = vecs[i].rt;
      @(negedge clk);
      chk($sformatf("v%0d_rs_data", i), bus0.RSdata_o, vecs[i].e_rs);
      chk($sformatf("v%0d_rt_data", i), bus0.RTdata_o, vecs[i].e_rt);
      chk($sformatf("v%0d_rs_busy", i), {31'b0, bus0.RSbusy_o}, {31'b0, vecs[i].e_rsb});
      chk($sformatf("v%0d_rt_busy", i), {31'b0, bus0.RTbusy_o}, {31'b0, vecs[i].e_rtb});
      chk($sformatf("v%0d_cnt", i), {26'b0, bus0.BusyCnt_o}, {26'b0, vecs[i].e_cnt});
      tick();
    end

    // Reset wins over a same-cycle write and issue.
    idle();
    rst = 1'b1;
    bus0.WAen_i = 1; bus0.WAaddr_i = 6; bus0.WAdata_i = 32'h5;
    bus0.Issue_i = 1; bus0.Issueaddr_i = 6;
    tick();
    rst = 1'b0;
    idle();
    bus0.RSaddr_i = 5; bus0.RTaddr_i = 6;
    @(negedge clk);
    chk("rst2_rs_data", bus0.RSdata_o, 32'h0);
    chk("rst2_rt_data", bus0.RTdata_o, 32'h0);
    chk("rst2_rt_busy", {31'b0, bus0.RTbusy_o}, 32'h0);
    chk("rst2_cnt", {26'b0, bus0.BusyCnt_o}, 32'h0);
    tick();

    // Fill the scoreboard: register 0 never counts, so the count tops out at 31.
    for (int a = 0; a < 32; a++) begin
      bus0.Issue_i = 1; bus0.Issueaddr_i = 5'(a);
      tick();
    end
    idle();
    bus0.RSaddr_i = 0; bus0.RTaddr_i = 31;
    @(negedge clk);
    chk("full_cnt", {26'b0, bus0.BusyCnt_o}, 32'd31);
    chk("full_x0_busy", {31'b0, bus0.RSbusy_o}, 32'h0);
    chk("full_x31_busy", {31'b0, bus0.RTbusy_o}, 32'h1);
    bus0.Flush_i = 1;
    tick();
    bus0.Flush_i = 0;
    @(negedge clk);
    chk("flush_all_cnt", {26'b0, bus0.BusyCnt_o}, 32'h0);
    chk("flush_all_busy", {31'b0, bus0.RTbusy_o}, 32'h0);
    tick();

    // Register 0 is ordinary storage when the zero register is disabled.
    bus1.WAen_i = 1; bus1.WAaddr_i = 0; bus1.WAdata_i = 32'h1234;
    bus1.Issue_i = 1; bus1.Issueaddr_i = 0;
    tick();
    idle();
    bus1.RSaddr_i = 0;
    @(negedge clk);
    chk("nz_x0_data", bus1.RSdata_o, 32'h1234);
    chk("nz_x0_busy", {31'b0, bus1.RSbusy_o}, 32'h1);
    chk("nz_cnt", {26'b0, bus1.BusyCnt_o}, 32'h1);
    tick();
    bus1.WBen_i = 1; bus1.WBaddr_i = 0; bus1.WBdata_i = 32'h5;
    bus1.RSaddr_i = 0;
    @(negedge clk);
    chk("nz_wb_bypass", bus1.RSdata_o, 32'h5);
    chk("nz_wb_busy", {31'b0, bus1.RSbusy_o}, 32'h0);
    tick();
    idle();
    @(negedge clk);
    chk("nz_wb_cnt", {26'b0, bus1.BusyCnt_o}, 32'h0);
    chk("nz_wb_stored", bus1.RSdata_o, 32'h5);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised general-purpose register file: next generation of the single-write-port CPU register bank.
- Adds a second write port, same-cycle write-to-read bypass, an optional hardwired-zero register 0, and synchronous reset of storage.
- Adds a per-register busy scoreboard (set at issue, cleared at writeback) with a registered busy count, so the hazard unit can stall on pending producers.
- Sits between decode (read/issue) and writeback (two retire lanes).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- ZERO_REG, 1, when 1 register 0 reads 0, ignores writes and is never marked busy.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous active-high reset.
- RSaddr_i  in  ADDR_W  read port S address.
- RTaddr_i  in  ADDR_W  read port T address.
- RSdata_o  out  DATA_W  read port S data.
- RTdata_o  out  DATA_W  read port T data.
- RSbusy_o  out  1  port S register has a pending producer.
- RTbusy_o  out  1  port T register has a pending producer.
- WAen_i  in  1  write port A enable.
- WAaddr_i  in  ADDR_W  write port A address.
- WAdata_i  in  DATA_W  write port A data.
- WBen_i  in  1  write port B enable.
- WBaddr_i  in  ADDR_W  write port B address.
- WBdata_i  in  DATA_W  write port B data.
- Issue_i  in  1  mark Issueaddr_i busy.
- Issueaddr_i  in  ADDR_W  destination being issued.
- Flush_i  in  1  clear all busy bits.
- BusyCnt_o  out  ADDR_W+1  registered number of busy registers.

Behaviour:
Reset:
- rst_i high at an edge: all registers <= 0, all busy bits <= 0, BusyCnt_o <= 0.
- Reset overrides writes, issue and flush in the same cycle.
- After reset, all data and busy outputs read 0.

Writes:
- Each enabled port writes at the rising edge.
- Both ports enabled to the same address: port B data is stored.
- ZERO_REG=1: writes to address 0 are dropped.

Reads:
- Combinational, zero latency.
- Bypass priority: port B write to the same address this cycle, then port A write to the same address this cycle, then stored value.
- ZERO_REG=1 and address 0: data is 0 and busy is 0, regardless of writes.

Busy bit update at each edge, per register r (ZERO_REG=1 excludes r=0):
- Flush_i clears every bit.
- A write on either port to r clears bit r.
- Issue_i with Issueaddr_i==r sets bit r; this overrides both the flush clear and the write clear in the same cycle (new producer).
- Issue_i to an already busy r leaves it busy. Single-bit scoreboard: only one producer in flight per register.

Busy read outputs:
- RSbusy_o/RTbusy_o = stored busy bit AND NOT (a write this cycle to that address).
- Current-cycle issue is not visible until the next cycle.

BusyCnt_o:
- Registered population count of the busy vector.
- Computed from the next-state vector so it matches the bits after the same edge.
- Range 0..2**ADDR_W (or 2**ADDR_W-1 with ZERO_REG).

Not checked:
- A write to a non-busy register is legal; bit stays 0.
- Writes with en low have no effect, whatever address and data are driven.

Test Plan:
- Reset: write x5=0xDEADBEEF, assert rst_i one cycle, read RS=5 -> RSdata_o=0, RSbusy_o=0, BusyCnt_o=0.
- Zero register: WA writes 0x1234 to x0 and Issue_i on x0, read RS=0 -> 0, not busy, BusyCnt_o unchanged; same with ZERO_REG=0 -> reads 0x1234 next cycle.
- Bypass and collision: same cycle WA x7=0x11, WB x7=0x22, RS=7 -> RSdata_o=0x22 combinationally; the next cycle RSdata_o=0x22 stored.
- Scoreboard: issue x3 -> next cycle RSbusy_o=1, BusyCnt_o=1; WB write x3=0x99 in the same cycle as read RS=3 -> RSbusy_o=0, RSdata_o=0x99; after the edge BusyCnt_o=0.
- Issue vs writeback: x4 busy; same cycle WA writes x4 and Issue_i x4 -> x4 data updated, x4 remains busy, BusyCnt_o unchanged.
- Flush: issue x1, x2, x9 (BusyCnt_o=3), then Flush_i with Issue_i x2 -> next cycle only x2 busy, BusyCnt_o=1.
